// File: rtl/cpu_mem_bridge.sv
// Arbitrates the instruction-fetch and data-access masters onto one
// variable-latency memory port, keeping exactly one transaction in flight.
module cpu_mem_bridge #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  // Handshakes: a master holds *_req until it sees *_addr_ok in the same
  // cycle; mem_req is held with stable fields until mem_addr_ok; each
  // mem_data_ok in WAIT yields exactly one *_data_ok to the owner.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  we_r;
  logic        owner_r;
  logic [2:0]  starve_cnt;
  logic        grant_inst;
  logic        grant_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      we_r       <= 4'd0;
      owner_r    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_inst) begin
        addr_r     <= inst_addr;
        wdata_r    <= 32'd0;
        we_r       <= 4'd0;
        owner_r    <= 1'b0;
        starve_cnt <= 3'd0;
      end else if (grant_data) begin
        addr_r  <= data_addr;
        wdata_r <= data_wdata;
        we_r    <= data_we;
        owner_r <= 1'b1;
        // Only data grants that actually bypass a waiting fetch count.
        if (inst_req) begin
          if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 3'd1;
        end else begin
          starve_cnt <= 3'd0;
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_inst   = 1'b0;
    grant_data   = 1'b0;
    mem_req      = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (inst_req && (!data_req || starve_cnt == STARVE_LIM)) begin
            grant_inst = 1'b1;
          end else if (data_req) begin
            grant_data = 1'b1;
          end
          if (grant_inst || grant_data) state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_addr_ok) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_data_ok) begin
          state_nxt = IDLE;
          // A response landing in a reset cycle is dropped.
          if (!reset) begin
            if (owner_r) data_data_ok = 1'b1;
            else         inst_data_ok = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;
  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign mem_wstrb    = we_r;
  assign mem_wr       = |we_r;
  assign state_dbg    = state;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: directed scenarios then random traffic, checked
// each cycle against a transaction-level model of arbitration and responses.
module tb_cpu_mem_bridge;

  localparam int STARVE_MAX = 4;
  localparam int W = 69;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic [1:0]  state_dbg;

  cpu_mem_bridge #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int          ao_lat    = 0;
  int          do_lat    = 0;
  bit          mem_rand  = 0;
  bit          spur_en   = 0;
  bit          dok_force = 0;
  bit          fix_rdata = 0;
  logic [31:0] rdata_val = 32'd0;
  bit          pend;
  int          req_cnt;
  int          wait_cnt;

  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'd0;
    pend        = 0;
    req_cnt     = 0;
    wait_cnt    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend    = 0;
        req_cnt = 0;
      end else begin
        if (mem_data_ok && pend) pend = 0;
        else if (pend) wait_cnt++;
        if (mem_req && mem_addr_ok) begin
          pend     = 1;
          wait_cnt = 0;
          req_cnt  = 0;
        end else if (mem_req) begin
          req_cnt++;
        end
      end
      @(posedge clk);
      #1;
      mem_addr_ok = mem_rand ? 1'($urandom_range(0, 1)) : (req_cnt >= ao_lat);
      if (pend) mem_data_ok = mem_rand ? 1'($urandom_range(0, 1)) : (wait_cnt >= do_lat);
      else      mem_data_ok = spur_en && ($urandom_range(0, 5) == 0);
      if (dok_force) mem_data_ok = 1'b1;
      mem_rdata = fix_rdata ? rdata_val : $urandom;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the accepted, not yet answered transaction:
  // {owner(1=data), we[3:0], addr[31:0], wdata[31:0]}.
  logic [W-1:0] exp_q[$];
  bit           issued;
  int           starve;
  int           cyc;
  bit           grant_log[$];
  int           grant_cyc_q[$];
  int           done_cyc_q[$];
  int           inst_done_n;
  int           data_done_n;
  logic [31:0]  last_inst_rdata;
  int           mem_req_cycles;
  logic [31:0]  last_mem_addr;
  logic         last_mem_wr;
  logic [3:0]   last_mem_wstrb;
  logic         exp_i;
  logic         exp_d;
  logic [W-1:0] cur;

  initial begin
    issued = 0; starve = 0; cyc = 0; inst_done_n = 0; data_done_n = 0;
    mem_req_cycles = 0; last_inst_rdata = 0; last_mem_addr = 0;
    last_mem_wr = 0; last_mem_wstrb = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (inst_addr_ok) begin grant_log.push_back(1'b0); grant_cyc_q.push_back(cyc); end
    if (data_addr_ok) begin grant_log.push_back(1'b1); grant_cyc_q.push_back(cyc); end
    if (inst_data_ok) begin inst_done_n++; last_inst_rdata = inst_rdata; done_cyc_q.push_back(cyc); end
    if (data_data_ok) begin data_done_n++; done_cyc_q.push_back(cyc); end
    if (reset) begin
      check("rst_inst_addr_ok", inst_addr_ok, 0);
      check("rst_data_addr_ok", data_addr_ok, 0);
      check("rst_inst_data_ok", inst_data_ok, 0);
      check("rst_data_data_ok", data_data_ok, 0);
      exp_q.delete();
      issued = 0;
      starve = 0;
    end else begin
      exp_i = (exp_q.size() == 0) && inst_req && (!data_req || starve == STARVE_MAX);
      exp_d = (exp_q.size() == 0) && data_req && !exp_i;
      check("inst_addr_ok", inst_addr_ok, exp_i);
      check("data_addr_ok", data_addr_ok, exp_d);
      check("mem_req", mem_req, (exp_q.size() != 0) && !issued);
      if (mem_req) begin
        mem_req_cycles++;
        last_mem_addr  = mem_addr;
        last_mem_wr    = mem_wr;
        last_mem_wstrb = mem_wstrb;
      end
      if (exp_q.size() != 0 && !issued) begin
        cur = exp_q[0];
        check("mem_addr", mem_addr, cur[63:32]);
        check("mem_wstrb", mem_wstrb, cur[67:64]);
        check("mem_wr", mem_wr, |cur[67:64]);
        if (|cur[67:64]) check("mem_wdata", mem_wdata, cur[31:0]);
        if (mem_addr_ok) issued = 1;
      end else if (exp_q.size() != 0 && mem_data_ok) begin
        cur = exp_q.pop_front();
        issued = 0;
        check("inst_data_ok", inst_data_ok, !cur[68]);
        check("data_data_ok", data_data_ok, cur[68]);
        if (!cur[68]) check("inst_rdata", inst_rdata, mem_rdata);
        else if (cur[67:64] == 4'd0) check("data_rdata", data_rdata, mem_rdata);
      end else begin
        check("inst_data_ok_idle", inst_data_ok, 0);
        check("data_data_ok_idle", data_data_ok, 0);
      end
      if (exp_i) begin
        exp_q.push_back({1'b0, 4'd0, inst_addr, 32'd0});
        starve = 0;
      end else if (exp_d) begin
        exp_q.push_back({1'b1, data_we, data_addr, data_wdata});
        if (inst_req) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
        else starve = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic i_ack;
  logic d_ack;

  task automatic tick();
    @(negedge clk);
    i_ack = inst_addr_ok;
    d_ack = data_addr_ok;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL idle_timeout: transaction still pending after %0d cycles", n);
    end
  endtask

  task automatic rand_masters();
    if (i_ack) inst_req = 1'b0;
    else if (inst_req && $urandom_range(0, 15) == 0) inst_req = 1'b0;
    if (!inst_req && $urandom_range(0, 2) == 0) begin
      inst_req  = 1'b1;
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_ack) data_req = 1'b0;
    else if (data_req && $urandom_range(0, 15) == 0) data_req = 1'b0;
    if (!data_req && $urandom_range(0, 2) == 0) begin
      data_req   = 1'b1;
      data_addr  = $urandom;
      data_wdata = $urandom;
      data_we    = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
    end
  endtask

  // ---------------- stimulus ----------------
  int inst_n0;
  int data_n0;
  int base;
  int d_left;
  int n;

  initial begin
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; inst_addr = 0;
    data_addr = 0; data_we = 0; data_wdata = 0; i_ack = 0; d_ack = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_state", state_dbg, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_inst_rdata", inst_rdata, 0);
    check("rst_data_rdata", data_rdata, 0);
    @(posedge clk);
    #2;

    // single instruction read, fastest memory
    fix_rdata = 1; rdata_val = 32'h02800C0C;
    base = grant_log.size();
    inst_req = 1'b1; inst_addr = 32'h1C000000;
    tick();
    check("t1_ack", i_ack, 1);
    inst_req = 1'b0;
    wait_idle();
    check("t1_grants", grant_log.size() - base, 1);
    check("t1_owner", grant_log[base], 0);
    check("t1_rdata", last_inst_rdata, 32'h02800C0C);
    check("t1_mem_addr", last_mem_addr, 32'h1C000000);
    check("t1_mem_wr", last_mem_wr, 0);
    check("t1_latency", done_cyc_q[done_cyc_q.size()-1] - grant_cyc_q[base], 2);
    fix_rdata = 0;

    // data write against slow memory
    ao_lat = 3; do_lat = 2;
    inst_n0 = inst_done_n; data_n0 = data_done_n; mem_req_cycles = 0;
    data_req = 1'b1; data_we = 4'b0011; data_addr = 32'h100; data_wdata = 32'hDEADBEEF;
    tick();
    check("t2_ack", d_ack, 1);
    data_req = 1'b0; data_we = 4'd0;
    wait_idle();
    check("t2_mem_req_cycles", mem_req_cycles, 4);
    check("t2_mem_wstrb", last_mem_wstrb, 4'b0011);
    check("t2_mem_wr", last_mem_wr, 1);
    check("t2_data_ok_pulses", data_done_n - data_n0, 1);
    check("t2_inst_ok_pulses", inst_done_n - inst_n0, 0);
    ao_lat = 0; do_lat = 0;

    // simultaneous requests
    base = grant_log.size();
    inst_req = 1'b1; inst_addr = 32'h1C000010;
    data_req = 1'b1; data_addr = 32'h200; data_we = 4'd0;
    n = 0;
    while ((inst_req || data_req) && n < 50) begin
      tick();
      if (i_ack) inst_req = 1'b0;
      if (d_ack) data_req = 1'b0;
      n++;
    end
    inst_req = 1'b0; data_req = 1'b0;
    wait_idle();
    check("t3_grants", grant_log.size() - base, 2);
    if (grant_log.size() - base == 2) begin
      check("t3_first", grant_log[base], 1);
      check("t3_second", grant_log[base+1], 0);
      check("t3_inst_after_resp", grant_cyc_q[base+1] - done_cyc_q[done_cyc_q.size()-2], 1);
    end

    // starvation: fetch held high against back-to-back data requests
    base = grant_log.size();
    inst_req = 1'b1; inst_addr = 32'h1C000020;
    data_req = 1'b1; data_addr = 32'h300; data_we = 4'd0;
    d_left = 6; n = 0;
    while (grant_log.size() - base < 6 && n < 200) begin
      tick();
      if (i_ack) inst_req = 1'b0;
      if (d_ack) begin
        d_left--;
        if (d_left == 0) data_req = 1'b0;
        else data_addr = data_addr + 32'h4;
      end
      n++;
    end
    inst_req = 1'b0; data_req = 1'b0;
    wait_idle();
    check("t4_grants", grant_log.size() - base, 6);
    if (grant_log.size() - base >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check($sformatf("t4_grant%0d", k), grant_log[base+k], (k == 4) ? 0 : 1);
      end
    end

    // reset in the same cycle as the memory response
    do_lat = 1000;
    data_n0 = data_done_n;
    data_req = 1'b1; data_addr = 32'h400; data_we = 4'd0;
    tick();
    check("t5_ack", d_ack, 1);
    data_req = 1'b0;
    dok_force = 1;
    tick();
    reset = 1'b1; dok_force = 0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_state", state_dbg, 0);
    check("t5_mem_req", mem_req, 0);
    check("t5_mem_wr", mem_wr, 0);
    check("t5_mem_wstrb", mem_wstrb, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_wdata", mem_wdata, 0);
    check("t5_data_rdata", data_rdata, 0);
    check("t5_no_pulse", data_done_n - data_n0, 0);
    @(posedge clk);
    #2;
    do_lat = 0;

    // spurious responses while idle
    inst_n0 = inst_done_n; data_n0 = data_done_n;
    dok_force = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_state", state_dbg, 0);
    end
    dok_force = 0;
    tick();
    check("t6_inst_pulses", inst_done_n - inst_n0, 0);
    check("t6_data_pulses", data_done_n - data_n0, 0);

    // random traffic with random memory timing and occasional resets
    mem_rand = 1; spur_en = 1;
    base = grant_log.size();
    for (int k = 0; k < 3000; k++) begin
      tick();
      rand_masters();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 149) == 0) reset = 1'b1;
    end
    inst_req = 1'b0; data_req = 1'b0; reset = 1'b0; spur_en = 0;
    tick();
    wait_idle();
    check("rand_activity", (grant_log.size() - base) > 200, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bridge.md
# cpu_mem_bridge

Single-port memory bridge between the core's instruction-fetch and data-access sides and one shared variable-latency memory port. It sits directly downstream of the CPU top: the IF stage issues instruction requests and the EXE/MEM stages issue data requests. The bridge arbitrates between them and keeps one transaction outstanding. It returns read data, with a one-cycle `*_data_ok` pulse, to the master that won.

## Interface
Parameters:
- `STARVE_MAX`, 4: consecutive data grants allowed while an instruction request is pending before the instruction side is forced to win once.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `inst_req` input 1: instruction read request; held until `inst_addr_ok`.
- `inst_addr` input 32: fetch address.
- `inst_addr_ok` output 1: request accepted this cycle.
- `inst_data_ok` output 1: one-cycle pulse; `inst_rdata` valid.
- `inst_rdata` output 32: fetched word.
- `data_req` input 1: data request; held until `data_addr_ok`.
- `data_we` input 4: byte write strobes; 0 means read.
- `data_addr` input 32: data address.
- `data_wdata` input 32: store data.
- `data_addr_ok` output 1: request accepted.
- `data_data_ok` output 1: one-cycle pulse; read data valid, or write complete.
- `data_rdata` output 32: load word.
- `mem_req` output 1: request to memory.
- `mem_wr` output 1: 1 for write.
- `mem_wstrb` output 4: byte strobes.
- `mem_addr` output 32: address.
- `mem_wdata` output 32: write data.
- `mem_addr_ok` input 1: memory accepted the request.
- `mem_data_ok` input 1: memory response valid.
- `mem_rdata` input 32: response data.

## Operation
- The FSM has three states: IDLE, REQ, WAIT.
- **IDLE**
  - If any master request is high, select a winner.
  - Pulse that master's `*_addr_ok` combinationally in this cycle.
  - Latch addr, we, wdata and the owner bit (0 = inst, 1 = data), then go to REQ.
  - With no request, stay in IDLE.
- **Arbitration**
  - Data wins over inst by default.
  - The starve counter increments on each data grant made while `inst_req` is high. It clears on any inst grant, and on any data grant made while `inst_req` is low.
  - When the counter equals `STARVE_MAX` and `inst_req` is high, inst wins even if `data_req` is high.
  - The counter is 3 bits and saturates at `STARVE_MAX`.
- **REQ**
  - `mem_req` = 1. `mem_addr`, `mem_wr` (= |we), `mem_wstrb` and `mem_wdata` are driven from the latched registers and stay stable.
  - On `mem_addr_ok`, go to WAIT.
- **WAIT**
  - `mem_req` = 0.
  - On `mem_data_ok`, pulse the owner's `*_data_ok` for that cycle and drive `*_rdata` = `mem_rdata` (combinational pass-through), then go to IDLE.
  - A write also completes on `mem_data_ok`. `data_rdata` is don't-care for writes.
- `mem_data_ok` is ignored in IDLE and REQ: no `*_data_ok` pulse and no state change.
- Master `*_addr_ok` is never asserted outside IDLE.
- The non-owner's `*_data_ok` is always 0.

## Timing
- Reset values:
  - state = IDLE and starve counter = 0.
  - All `*_addr_ok`, `*_data_ok` and `mem_req` = 0.
  - `mem_wr` = 0, `mem_wstrb` = 0, `mem_addr`, `mem_wdata` and `*_rdata` = 0.
- Minimum transaction is 3 cycles: cycle 0 accept (IDLE), cycle 1 `mem_req` with `mem_addr_ok` high, cycle 2 `mem_data_ok` with `*_data_ok`.
- The next accept is possible in cycle 3. Throughput is at most one transaction per 3 cycles.
- `mem_addr_ok` is sampled only while `mem_req` = 1.
- Reset in REQ or WAIT:
  - Return to IDLE next cycle.
  - The pending response is dropped; a `mem_data_ok` in the reset cycle produces no master pulse.
  - The starve counter clears.
- If a master drops its request without seeing `addr_ok`, nothing is latched.
- Simultaneous `inst_req` and `data_req` in IDLE: exactly one `addr_ok` is pulsed, and the loser stays pending.

## Test plan
- **Single inst read:** `inst_req` = 1, `inst_addr` = 0x1C000000; memory gives `addr_ok` in cycle 1 and `data_ok` in cycle 2 with 0x02800C0C -> `inst_addr_ok` in cycle 0, `mem_addr` = 0x1C000000 and `mem_wr` = 0, `inst_data_ok` = 1 with `inst_rdata` = 0x02800C0C in cycle 2.
- **Data write with slow memory:** `data_we` = 4'b0011, `data_addr` = 0x100, `data_wdata` = 0xDEADBEEF; `mem_addr_ok` delayed 3 cycles, `mem_data_ok` delayed 2 more -> `mem_req` high for 4 cycles with stable fields and `mem_wstrb` = 0011; a single `data_data_ok` pulse; `inst_data_ok` never asserted.
- **Simultaneous requests:** both requests high in IDLE -> the data request is granted first and the inst request is granted in the IDLE cycle after the data response.
- **Starvation:** `inst_req` held high with 6 back-to-back data requests and `STARVE_MAX` = 4 -> grant order D, D, D, D, I, D.
- **Reset mid-WAIT:** `reset` asserted in the same cycle as `mem_data_ok` -> no `*_data_ok` pulse, state = IDLE, all outputs at their reset values next cycle.
- **Spurious response:** `mem_data_ok` = 1 while in IDLE with no requests -> no output changes and the FSM stays in IDLE.
